// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Contents: loader state enum, word/byte geometry constants.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE,
        ERROR
    } state_e;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream link feeding the boot loader.
// Signals: in_valid/in_ready handshake, in_data stream byte, in_last marks
// the final byte of an image (qualified by in_valid).
// master = byte source (host/debug link), slave = boot loader.
interface imem_boot_loader_if;

    logic                               in_valid;
    logic                               in_ready;
    logic [imem_loader_pkg::BYTE_W-1:0] in_data;
    logic                               in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/imem_boot_loader_packer.sv
// byte_to_word_packer: assembles little-endian 32-bit words from bytes.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   clear           restart assembly at byte lane 0 (new load)
//   byte_valid      a byte is accepted this edge
//   byte_data       the accepted byte
//   byte_last       accepted byte is the last of the image
//   word_valid      one-cycle strobe: word_data is a complete word
//   word_data       assembled word, unfilled upper lanes are zero
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              byte_last,
    output logic              word_valid,
    output logic [31:0]       word_data
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] byte_idx;
    logic [31:0]      asm_q;
    logic [31:0]      asm_next;
    logic             word_end;

    always_comb begin
        asm_next = asm_q;
        case (byte_idx)
            2'd0:    asm_next[7:0]   = byte_data;
            2'd1:    asm_next[15:8]  = byte_data;
            2'd2:    asm_next[23:16] = byte_data;
            default: asm_next[31:24] = byte_data;
        endcase
    end

    // A short final word is emitted as-is; asm_q is zeroed after every word
    // so the unfilled upper lanes read back as zero.
    assign word_end = (byte_idx == LAST_IDX) | byte_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_idx   <= '0;
            asm_q      <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else if (clear) begin
            byte_idx   <= '0;
            asm_q      <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                if (word_end) begin
                    word_valid <= 1'b1;
                    word_data  <= asm_next;
                    asm_q      <= '0;
                    byte_idx   <= '0;
                end else begin
                    asm_q    <= asm_next;
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: writes a byte-streamed program image into instruction
// memory and holds the core in reset until the image is complete.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   start           one-cycle pulse, begins a load at word address 0
//   byte_in         byte-stream slave (in_valid/in_ready/in_data/in_last)
//   imem_we         write strobe, one cycle per word
//   imem_addr       word address of the write
//   imem_wdata      write data
//   cpu_hold        1 keeps the core in reset
//   busy/done/err   status: LOAD or FLUSH / DONE / ERROR
//   words_loaded    words written by the current or last load
//
// state | meaning
// IDLE  | after reset, no image loaded, stream not accepted
// LOAD  | accepting bytes, writing each completed word
// FLUSH | final word being written, stream closed
// DONE  | image complete, core released
// ERROR | image exceeded imem depth; bytes sunk until next start
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_boot_loader_if.slave byte_in,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] waddr;
    logic              accept;
    logic              load_byte;
    logic              overflow;
    logic              start_ok;
    logic              pack_valid;
    logic              word_valid;
    logic [31:0]       word_data;

    assign byte_in.in_ready = (state_q == LOAD) || (state_q == ERROR);
    assign accept    = byte_in.in_valid & byte_in.in_ready;
    assign load_byte = accept & (state_q == LOAD);

    // words_loaded lags a pending write by one cycle, so count that write
    // too; otherwise a byte arriving right behind the DEPTH-th word slips in.
    assign overflow   = load_byte &
                        ((words_loaded + {{ADDR_W{1'b0}}, word_valid}) == DEPTH);
    assign pack_valid = load_byte & ~overflow;
    assign start_ok   = start &
                        ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));

    byte_to_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .byte_valid (pack_valid),
        .byte_data  (byte_in.in_data),
        .byte_last  (byte_in.in_last),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (overflow)
                    state_d = ERROR;
                else if (pack_valid && byte_in.in_last)
                    state_d = FLUSH;
            end
            FLUSH: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = LOAD;
            end
            ERROR: begin
                err = 1'b1;
                if (start) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            waddr        <= '0;
            words_loaded <= '0;
            cpu_hold     <= 1'b1;
        end else begin
            state_q  <= state_d;
            // Registered from next state so the core reset line is glitch-free.
            cpu_hold <= (state_d != DONE);
            if (start_ok) begin
                waddr        <= '0;
                words_loaded <= '0;
            end else if (word_valid) begin
                waddr        <= waddr + 1'b1;
                words_loaded <= words_loaded + 1'b1;
            end
        end
    end

    assign imem_we    = word_valid;
    assign imem_addr  = waddr;
    assign imem_wdata = word_data;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Drives one byte stream into two loaders (256-word and 4-word imem) and
// checks both against a byte-counting reference model through a write
// scoreboard and per-cycle status comparisons.
module tb_imem_boot_loader;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } wr_t;

    localparam int M_IDLE = 0, M_LOAD = 1, M_FLUSH = 2, M_DONE = 3, M_ERR = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic       in_last;
    logic [7:0] in_data;

    logic [1:0]       we, hold, busy, done, err, rdy;
    logic [1:0][31:0] wdata;
    logic [7:0]       addr_b;
    logic [1:0]       addr_s;
    logic [8:0]       wl_b;
    logic [2:0]       wl_s;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    wr_t q_b[$];
    wr_t q_s[$];

    int          m_state[2];
    int          m_words[2];
    int          m_wl[2];
    int          m_nb[2];
    logic [31:0] m_acc[2];
    bit          m_pend[2];
    int          depth[2] = '{256, 4};

    imem_boot_loader_if if_b ();
    imem_boot_loader_if if_s ();

    assign if_b.in_valid = in_valid;
    assign if_b.in_data  = in_data;
    assign if_b.in_last  = in_last;
    assign if_s.in_valid = in_valid;
    assign if_s.in_data  = in_data;
    assign if_s.in_last  = in_last;
    assign rdy[0] = if_b.in_ready;
    assign rdy[1] = if_s.in_ready;

    imem_boot_loader #(.ADDR_W(8), .WORD_W(32)) u_big (
        .clk(clk), .reset(reset), .start(start), .byte_in(if_b.slave),
        .imem_we(we[0]), .imem_addr(addr_b), .imem_wdata(wdata[0]),
        .cpu_hold(hold[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
        .words_loaded(wl_b)
    );

    imem_boot_loader #(.ADDR_W(2), .WORD_W(32)) u_small (
        .clk(clk), .reset(reset), .start(start), .byte_in(if_s.slave),
        .imem_we(we[1]), .imem_addr(addr_s), .imem_wdata(wdata[1]),
        .cpu_hold(hold[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
        .words_loaded(wl_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int get_addr(int k);
        return (k == 0) ? int'(addr_b) : int'(addr_s);
    endfunction

    function automatic int get_wl(int k);
        return (k == 0) ? int'(wl_b) : int'(wl_s);
    endfunction

    task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    endtask

    // ---------------- write scoreboard monitor ----------------
    always @(negedge clk) begin
        wr_t  e;
        logic got;
        for (int k = 0; k < 2; k++) begin
            if (we[k] === 1'b1) begin
                got = 1'b0;
                if (k == 0 && q_b.size() > 0) begin e = q_b.pop_front(); got = 1'b1; end
                if (k == 1 && q_s.size() > 0) begin e = q_s.pop_front(); got = 1'b1; end
                if (!got) chk("spurious_we", k, 1, 0);
                else begin
                    chk("wr_addr", k, get_addr(k), e.addr);
                    chk("wr_data", k, wdata[k], e.data);
                    chk("wr_cycle", k, cyc, e.cyc);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = M_IDLE;
            m_words[k] = 0; m_wl[k] = 0; m_nb[k] = 0; m_acc[k] = 0; m_pend[k] = 0;
        end
        q_b.delete();
        q_s.delete();
    endtask

    // End-of-cycle effects: a write finishing bumps the count, FLUSH lasts one cycle.
    task automatic model_tick();
        for (int k = 0; k < 2; k++) begin
            if (m_pend[k]) begin m_wl[k]++; m_pend[k] = 0; end
            if (m_state[k] == M_FLUSH) m_state[k] = M_DONE;
        end
    endtask

    task automatic model_byte(int k, logic [7:0] b, logic l, int e);
        wr_t w;
        if (m_state[k] != M_LOAD) return;
        if (m_words[k] == depth[k]) begin m_state[k] = M_ERR; return; end
        m_acc[k] = m_acc[k] + (32'(b) << (8 * m_nb[k]));
        m_nb[k]++;
        if (m_nb[k] == 4 || l) begin
            w.cyc = e; w.addr = m_words[k]; w.data = m_acc[k];
            if (k == 0) q_b.push_back(w); else q_s.push_back(w);
            m_words[k]++; m_pend[k] = 1; m_nb[k] = 0; m_acc[k] = 0;
            if (l) m_state[k] = M_FLUSH;
        end
    endtask

    task automatic check_status();
        int st;
        for (int k = 0; k < 2; k++) begin
            st = m_state[k];
            chk("cpu_hold", k, hold[k], st != M_DONE);
            chk("busy", k, busy[k], st == M_LOAD || st == M_FLUSH);
            chk("done", k, done[k], st == M_DONE);
            chk("err", k, err[k], st == M_ERR);
            chk("in_ready", k, rdy[k], st == M_LOAD || st == M_ERR);
            chk("words_loaded", k, get_wl(k), m_wl[k]);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            model_tick();
            check_status();
        end
    endtask

    task automatic pulse_start();
        bit ok[2];
        for (int k = 0; k < 2; k++)
            ok[k] = (m_state[k] == M_IDLE || m_state[k] == M_DONE || m_state[k] == M_ERR);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_tick();
        for (int k = 0; k < 2; k++) begin
            if (ok[k]) begin
                m_state[k] = M_LOAD;
                m_words[k] = 0; m_wl[k] = 0; m_nb[k] = 0; m_acc[k] = 0; m_pend[k] = 0;
            end
        end
        check_status();
    endtask

    task automatic send_byte(logic [7:0] b, logic l, int gap);
        logic [1:0] r;
        idle(gap);
        in_valid = 1'b1; in_data = b; in_last = l;
        r = rdy;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        model_tick();
        for (int k = 0; k < 2; k++)
            if (r[k]) model_byte(k, b, l, cyc);
        check_status();
    endtask

    task automatic send_image(logic [7:0] img[$], int maxgap, int mid_start);
        for (int i = 0; i < img.size(); i++) begin
            if (i == mid_start) pulse_start();
            send_byte(img[i], i == img.size() - 1, $urandom_range(0, maxgap));
        end
        idle(2);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check_status();
        for (int k = 0; k < 2; k++) begin
            chk("rst_imem_we", k, we[k], 0);
            chk("rst_imem_addr", k, get_addr(k), 0);
            chk("rst_imem_wdata", k, wdata[k], 0);
        end
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] img[$];
        logic [7:0] img1[$];
        int         len;

        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        idle(2);

        img1 = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};

        // two full words back-to-back
        pulse_start();
        send_image(img1, 0, -1);

        // short final word
        pulse_start();
        img = '{8'h13, 8'h00, 8'h10, 8'h00, 8'hEF};
        send_image(img, 0, -1);

        // same image with valid gaps
        pulse_start();
        send_image(img1, 3, -1);

        // overflow of the 4-word instance, then an exact-fit image
        pulse_start();
        img.delete();
        for (int i = 0; i < 17; i++) img.push_back(8'($urandom));
        send_image(img, 0, -1);
        pulse_start();
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
        send_image(img, 1, -1);

        // reset in the middle of a load, then bytes offered while idle
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(img1[i], 1'b0, 0);
        do_reset();
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'h55, 1'b1, 1);
        idle(2);

        // start ignored mid-load, then restart from DONE
        pulse_start();
        send_image(img1, 0, 3);
        pulse_start();
        img.delete();
        for (int i = 0; i < 9; i++) img.push_back(8'($urandom));
        send_image(img, 0, -1);

        // random images, some overflowing the small instance, some restarted mid-load
        for (int n = 0; n < 12; n++) begin
            pulse_start();
            img.delete();
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            send_image(img, 2, ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : -1);
        end

        idle(3);
        chk("drain_q", 0, q_b.size(), 0);
        chk("drain_q", 1, q_s.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Loads a RISC-V program into instruction memory from a byte stream. It is the write side of the instruction memory whose read side is the core's fetch path. It holds the core in reset (cpu_hold) until a complete image has been written, then releases it. It sits between the host/debug byte link and the imem write port, beside the processor top level.

Parameters:
ADDR_W, 8, imem word-address width; depth DEPTH = 2**ADDR_W words
WORD_W, 32, imem word width; fixed at 32 (4 bytes per word)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
start  input  1  single-cycle pulse; begins a load from address 0
in_valid  input  1  byte-stream valid
in_ready  output  1  byte-stream ready
in_data  input  8  stream byte
in_last  input  1  marks final byte of image; qualified by in_valid
imem_we  output  1  imem write strobe, one cycle per word
imem_addr  output  ADDR_W  imem word address
imem_wdata  output  32  imem write data
cpu_hold  output  1  1 = keep core in reset
busy  output  1  1 in LOAD or FLUSH
done  output  1  1 in DONE
err  output  1  1 in ERROR
words_loaded  output  ADDR_W+1  words written in current or last load

Behaviour:
- Reset (reset==0 at an edge): state=IDLE. Outputs: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=0, words_loaded=0. Clears byte_idx and the assembly register. Reset mid-load aborts it; no further writes occur.
- States: IDLE, LOAD, FLUSH, DONE, ERROR.
- IDLE/DONE/ERROR + start: LOAD next cycle. Clears waddr, byte_idx, assembly register and words_loaded. Sets cpu_hold=1. start in LOAD/FLUSH is ignored.
- Handshake: a byte transfers when in_valid & in_ready. in_ready=1 in LOAD and ERROR, 0 otherwise. No stall occurs in LOAD because writes are registered and never back-pressure.
- Assembly: little-endian. The byte at byte_idx k goes to bits [8k+7:8k]. byte_idx wraps 3->0.
- Word write: if a transfer at edge T has byte_idx==3 or in_last, then during cycle T+1:
  - imem_we=1, imem_addr=waddr, imem_wdata=assembled word with unfilled upper bytes = 0.
  - waddr and words_loaded increment at the end of T+1.
  - imem_we is 0 in all other cycles.
- Back-to-back: bytes may arrive every cycle. A write in T+1 overlaps acceptance of the next word's byte 0.
- in_last accepted in LOAD: FLUSH (carries the final write). Next cycle DONE, with cpu_hold=0 and done=1. The last write therefore precedes hold release by exactly one cycle.
- in_last on a byte_idx==0 boundary still writes (a 1-byte word). A stream never ends without a write.
- Overflow: words_loaded==DEPTH and a further byte is accepted in LOAD -> ERROR next cycle, with no write for that byte.
  - ERROR sets err=1 and keeps cpu_hold=1.
  - ERROR sinks and drops all bytes (including in_last) and remains until start.
  - An image of exactly DEPTH words ending with in_last is legal and reaches DONE.
- waddr wraps naturally at DEPTH. Wrapped writes never occur because of the overflow check.
- cpu_hold stays 0 in DONE until the next start or reset.

Decomposition:
- Shared package imem_loader_pkg: state enum (IDLE, LOAD, FLUSH, DONE, ERROR), BYTES_PER_WORD=4, byte-lane width constant.
- One sub-module: byte_to_word_packer. It holds byte_idx, the assembly register and the write-pending flag, and outputs word_valid/word_data.
- The FSM, address counter and hold logic remain in the top module.

Test Plan:
1. start; bytes 13 00 10 00 93 00 50 00, with in_last on the 8th -> writes addr0=00100013 and addr1=00500093, one cycle after each 4th byte. FLUSH then DONE; cpu_hold falls one cycle after the second write; words_loaded=2.
2. start; 5 bytes 13 00 10 00 EF, with in_last on EF -> addr0=00100013, addr1=000000EF; done=1.
3. Same image as test 1, with in_valid gaps of 0-3 random cycles -> identical writes and data; in_ready=1 throughout LOAD; no spurious imem_we.
4. ADDR_W=2; 17 bytes, last flagged on byte 17 -> exactly 4 writes (addr0-3); err=1 after the 17th byte; cpu_hold=1; no 5th write. With ADDR_W=2 and 16 bytes, last flagged -> DONE, err=0.
5. reset=0 for one cycle after 6 bytes of a load -> no further imem_we. All outputs return to reset values (cpu_hold=1, words_loaded=0) and in_ready=0 until start.
6. start pulsed mid-LOAD -> ignored and the load completes normally. start in DONE -> cpu_hold=1 next cycle and the new image is written from addr0.
